// File: rtl/piso_tx_if.sv
// piso_tx load/serial bus bundle.
// master = word source + bit sink, slave = serializer.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] pdata;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, pdata,
    input  load_ready, sout, sout_valid,
    input  sout_first, busy, done
  );

  modport slave (
    input  load_valid, pdata,
    output load_ready, sout, sout_valid,
    output sout_first, busy, done
  );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: MSB-first parallel-in serial-out transmitter.
// Define PISO_TX_PARITY_EN to append an even-parity bit.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input logic   clk,
  input logic   rst_n,
  piso_tx_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PISO_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           st;
  state_t           nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             rdy;
  logic             so;
  logic             sv;
  logic             sf;
  logic             dn;
  logic             load;
`ifdef PISO_TX_PARITY_EN
  logic             par;
`endif

  assign load = bus.load_valid & rdy;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  // next state and outputs
  always_comb begin
    nxt = st;
    rdy = 1'b0;
    so  = 1'b0;
    sv  = 1'b0;
    sf  = 1'b0;
    dn  = 1'b0;
    unique case (st)
      IDLE: begin
        rdy = 1'b1;
        if (bus.load_valid) nxt = SHIFT;
      end
      SHIFT: begin
        sv = 1'b1;
        so = sreg[WIDTH-1];
        sf = (cnt == LAST);
        if (cnt == '0) begin
`ifdef PISO_TX_PARITY_EN
          nxt = PARITY;
`else
          dn  = 1'b1;
          rdy = 1'b1;
          nxt = bus.load_valid ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        sv  = 1'b1;
        so  = par;
        dn  = 1'b1;
        rdy = 1'b1;
        nxt = bus.load_valid ? SHIFT : IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  // shift register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= bus.pdata;
      cnt  <= LAST;
    end else if (st == SHIFT) begin
      sreg <= sreg << 1;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

`ifdef PISO_TX_PARITY_EN
  // parity of the word, latched at load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    par <= 1'b0;
    else if (load) par <= ^bus.pdata;
  end
`endif

  assign bus.load_ready = rdy;
  assign bus.sout       = so;
  assign bus.sout_valid = sv;
  assign bus.sout_first = sf;
  assign bus.busy       = (st != IDLE);
  assign bus.done       = dn;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed + random stimulus for piso_tx.
// Scoreboard queue holds every bit still owed on sout.
module tb_piso_tx;
  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic b;
    logic f;
    logic d;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  ex_t  q[$];

  piso_tx_if #(.WIDTH(W)) ifc ();

  piso_tx #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic a, input logic e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    ifc.load_valid = v;
    ifc.pdata      = d;
  endtask

  // model: an owed bit queue; ready whenever at most the
  // currently shown bit is still owed
  always @(negedge clk) begin
    if (rst_n) begin
      automatic bit rdy = (q.size() <= 1);
      automatic bit ev  = (q.size() > 0);
      automatic ex_t e  = '{1'b0, 1'b0, 1'b0};
      if (ev) e = q.pop_front();
      chk("valid", ifc.sout_valid, ev);
      chk("busy",  ifc.busy, ev);
      chk("ready", ifc.load_ready, rdy);
      chk("sout",  ifc.sout, e.b);
      chk("first", ifc.sout_first, e.f);
      chk("done",  ifc.done, e.d);
      if (ifc.load_valid && rdy) begin
        for (int k = 0; k < W; k++)
          q.push_back('{ifc.pdata[W-1-k], k == 0,
                        (k == W-1) && !PAR});
        if (PAR) q.push_back('{^ifc.pdata, 1'b0, 1'b1});
      end
    end
  end

  initial begin
    ifc.load_valid = 1'b0;
    ifc.pdata      = '0;
    #3;
    chk("rst_valid", ifc.sout_valid, 1'b0);
    chk("rst_busy",  ifc.busy, 1'b0);
    chk("rst_done",  ifc.done, 1'b0);
    chk("rst_sout",  ifc.sout, 1'b0);
    chk("rst_first", ifc.sout_first, 1'b0);
    #9 rst_n = 1'b1;

    // idle: nothing emitted
    repeat (10) drive(1'b0, 4'h0);

    // single word from idle
    drive(1'b1, 4'b1011);
    repeat (W + 3) drive(1'b0, 4'h0);

    // back-to-back words, no gap
    drive(1'b1, 4'hA);
    repeat (W) drive(1'b1, 4'h5);
    repeat (W + 3) drive(1'b0, 4'h0);

    // offer while busy is ignored
    drive(1'b1, 4'h6);
    drive(1'b0, 4'h0);
    drive(1'b1, 4'hF);
    repeat (W + 3) drive(1'b0, 4'h0);

    // parity cases
    drive(1'b1, 4'b0111);
    drive(1'b0, 4'h0);
    repeat (W + 1) drive(1'b0, 4'h0);
    drive(1'b1, 4'b0110);
    repeat (W + 3) drive(1'b0, 4'h0);

    // reset mid-word aborts it
    drive(1'b1, 4'hC);
    drive(1'b0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", ifc.sout_valid, 1'b0);
    chk("mid_busy",  ifc.busy, 1'b0);
    chk("mid_sout",  ifc.sout, 1'b0);
    chk("mid_first", ifc.sout_first, 1'b0);
    chk("mid_done",  ifc.done, 1'b0);
    q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 4'h0);
    @(posedge clk);
    #3;
    ifc.load_valid = 1'b1;
    ifc.pdata      = 4'h9;
    repeat (W + 3) drive(1'b0, 4'h0);

    // random traffic
    for (int i = 0; i < 500; i++)
      drive($urandom_range(0, 3) != 0, W'($urandom));
    repeat (W + 4) drive(1'b0, 4'h0);
    @(negedge clk);
    chk("drained", q.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
